glyph_renderer: RTL and testbench

GLYPH_RENDERER -- requirements
Module: glyph_renderer

---
 rtl/glyph_renderer_if.sv | 28 ++
 rtl/glyph_renderer.sv | 120 ++++++++++++
 tb/tb_glyph_renderer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/glyph_renderer_if.sv
// Character request, font ROM and pixel stream signals of the glyph renderer.
// The slave modport is the renderer side; the master modport is its environment.
interface glyph_renderer_if;
   logic        char_valid;
   logic        char_ready;
   logic [7:0]  char_code;
   logic [15:0] fg_color;
   logic [15:0] bg_color;
   logic [11:0] rom_ad;
   logic        rom_ce;
   logic        rom_oce;
   logic [7:0]  rom_dout;
   logic        pix_valid;
   logic        pix_ready;
   logic [15:0] pix_data;
   logic        pix_last;
   logic        busy;

   modport master (
      output char_valid, char_code, fg_color, bg_color, rom_dout, pix_ready,
      input  char_ready, rom_ad, rom_ce, rom_oce, pix_valid, pix_data, pix_last, busy
   );

   modport slave (
      input  char_valid, char_code, fg_color, bg_color, rom_dout, pix_ready,
      output char_ready, rom_ad, rom_ce, rom_oce, pix_valid, pix_data, pix_last, busy
   );
endinterface

// File: rtl/glyph_renderer.sv
// Expands one 8 x ROWS font glyph, fetched row by row from a synchronous ROM,
// into a stream of RGB565 pixels with a valid/ready handshake.
module glyph_renderer #(
   parameter int unsigned ROWS     = 16,
   parameter bit          MSB_LEFT = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   glyph_renderer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StLatch, StShift} state_e;

   localparam logic [3:0] LastRow = 4'(ROWS - 1);

   state_e      state_q, state_d;
   logic        init_q;
   logic [7:0]  code_q, code_d;
   logic [15:0] fg_q, fg_d;
   logic [15:0] bg_q, bg_d;
   logic [3:0]  row_q, row_d;
   logic [2:0]  col_q, col_d;
   logic [7:0]  sh_q, sh_d;

   logic        char_ready;
   logic        rom_ce;
   logic        pix_valid;
   logic        pix_last;
   logic [15:0] pix_data;
   logic        cur_bit;

   assign cur_bit = MSB_LEFT ? sh_q[7] : sh_q[0];

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      fg_d       = fg_q;
      bg_d       = bg_q;
      row_d      = row_q;
      col_d      = col_q;
      sh_d       = sh_q;
      char_ready = 1'b0;
      rom_ce     = 1'b0;
      pix_valid  = 1'b0;
      pix_last   = 1'b0;
      pix_data   = 16'h0000;
      unique case (state_q)
         StIdle: begin
            // init_q keeps char_ready low until the first edge after reset release
            char_ready = init_q;
            if (bus.char_valid && init_q) begin
               code_d  = bus.char_code;
               fg_d    = bus.fg_color;
               bg_d    = bus.bg_color;
               row_d   = 4'd0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            rom_ce  = 1'b1;
            state_d = StLatch;
         end
         StLatch: begin
            sh_d    = bus.rom_dout;
            col_d   = 3'd0;
            state_d = StShift;
         end
         StShift: begin
            pix_valid = 1'b1;
            pix_data  = cur_bit ? fg_q : bg_q;
            pix_last  = (row_q == LastRow) && (col_q == 3'd7);
            if (bus.pix_ready) begin
               col_d = 3'(col_q + 3'd1);
               sh_d  = MSB_LEFT ? {sh_q[6:0], 1'b0} : {1'b0, sh_q[7:1]};
               if (col_q == 3'd7) begin
                  if (row_q == LastRow) begin
                     state_d = StIdle;
                  end else begin
                     row_d   = 4'(row_q + 4'd1);
                     state_d = StFetch;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         init_q  <= 1'b0;
         code_q  <= 8'h00;
         fg_q    <= 16'h0000;
         bg_q    <= 16'h0000;
         row_q   <= 4'd0;
         col_q   <= 3'd0;
         sh_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         init_q  <= 1'b1;
         code_q  <= code_d;
         fg_q    <= fg_d;
         bg_q    <= bg_d;
         row_q   <= row_d;
         col_q   <= col_d;
         sh_q    <= sh_d;
      end
   end

   assign bus.char_ready = char_ready;
   assign bus.rom_ad     = {code_q, row_q};
   assign bus.rom_ce     = rom_ce;
   assign bus.rom_oce    = rom_ce;
   assign bus.pix_valid  = pix_valid;
   assign bus.pix_data   = pix_data;
   assign bus.pix_last   = pix_last;
   assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_glyph_renderer.sv
// Self-checking bench: two renderer instances (16 rows MSB-left, 3 rows LSB-left)
// compared against a pixel-index reference model of the glyph expansion.
module tb_glyph_renderer;

   localparam int unsigned RowsA = 16;
   localparam int unsigned RowsB = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   int         rom_mode  = 0;
   logic [7:0] rom_const = 8'hA5;

   glyph_renderer_if bus_a ();
   glyph_renderer_if bus_b ();

   glyph_renderer #(.ROWS(RowsA), .MSB_LEFT(1'b1)) u_dut_a (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_a)
   );

   glyph_renderer #(.ROWS(RowsB), .MSB_LEFT(1'b0)) u_dut_b (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_b)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_byte(input logic [11:0] ad);
      logic [31:0] h;
      if (rom_mode == 0) return rom_const;
      h = 32'(ad) * 32'd2654435761;
      return h[23:16];
   endfunction

   // Synchronous font ROM: data appears the cycle after a clock-enabled read.
   always @(posedge clk) begin
      if (bus_a.rom_ce && bus_a.rom_oce) bus_a.rom_dout <= rom_byte(bus_a.rom_ad);
      if (bus_b.rom_ce && bus_b.rom_oce) bus_b.rom_dout <= rom_byte(bus_b.rom_ad);
   end

   // Pixel n of a glyph is row n/8, column n%8 counted from the left.
   function automatic logic [15:0] exp_pix(input logic [7:0] code, input int n,
                                           input logic [15:0] fg, input logic [15:0] bg,
                                           input bit msb_left);
      logic [7:0] b;
      int         r;
      int         k;
      r = n / 8;
      k = n % 8;
      b = rom_byte({code, 4'(r)});
      return b[msb_left ? 7 - k : k] ? fg : bg;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called and returns at a falling edge.
   task automatic render_a(input logic [7:0] code, input logic [15:0] fg, input logic [15:0] bg,
                           input bit rnd, input bit hold, input logic [7:0] nxt,
                           input int abort_at, input bit immediate);
      int          wait_n = 0;
      int          t = 1;
      int          npix = 0;
      int          first_ce = -1;
      int          first_pv = -1;
      bit          done = 1'b0;
      bit          prev_stall = 1'b0;
      logic [15:0] prev_data = 16'h0;
      logic        prev_last = 1'b0;
      logic [11:0] ads[$];
      bus_a.char_code  = code;
      bus_a.fg_color   = fg;
      bus_a.bg_color   = bg;
      bus_a.char_valid = 1'b1;
      while (!bus_a.char_ready && wait_n < 40) begin
         @(negedge clk);
         wait_n++;
      end
      if (immediate) check_eq("accept_wait", 32'(wait_n), 32'd0);
      check_eq("char_ready_before", 32'(bus_a.char_ready), 32'd1);
      if (!bus_a.char_ready) return;
      @(negedge clk);
      if (hold) begin
         bus_a.char_code = nxt;
         bus_a.fg_color  = ~fg;
         bus_a.bg_color  = ~bg;
      end else begin
         bus_a.char_valid = 1'b0;
         bus_a.char_code  = 8'($urandom);
         bus_a.fg_color   = 16'($urandom);
         bus_a.bg_color   = 16'($urandom);
      end
      bus_a.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!done && t < 40 * int'(RowsA)) begin
         check_eq("rom_oce", 32'(bus_a.rom_oce), 32'(bus_a.rom_ce));
         check_eq("busy", 32'(bus_a.busy), 32'd1);
         check_eq("char_ready_busy", 32'(bus_a.char_ready), 32'd0);
         if (bus_a.rom_ce) begin
            if (first_ce < 0) first_ce = t;
            ads.push_back(bus_a.rom_ad);
         end
         if (prev_stall) begin
            check_eq("stall_valid", 32'(bus_a.pix_valid), 32'd1);
            check_eq("stall_data", 32'(bus_a.pix_data), 32'(prev_data));
            check_eq("stall_last", 32'(bus_a.pix_last), 32'(prev_last));
         end
         if (bus_a.pix_valid) begin
            if (first_pv < 0) first_pv = t;
            if (npix == abort_at) return;
            check_eq("pix_data", 32'(bus_a.pix_data), 32'(exp_pix(code, npix, fg, bg, 1'b1)));
            check_eq("pix_last", 32'(bus_a.pix_last), 32'(npix == 8 * int'(RowsA) - 1));
            if (bus_a.pix_ready) begin
               npix++;
               prev_stall = 1'b0;
               done = (npix == 8 * int'(RowsA));
            end else begin
               prev_stall = 1'b1;
               prev_data  = bus_a.pix_data;
               prev_last  = bus_a.pix_last;
            end
         end else begin
            check_eq("pix_last_novalid", 32'(bus_a.pix_last), 32'd0);
            prev_stall = 1'b0;
         end
         if (!done) begin
            @(negedge clk);
            t++;
            bus_a.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
      check_eq("pixel_count", 32'(npix), 32'(8 * RowsA));
      @(negedge clk);
      t++;
      bus_a.pix_ready = 1'b1;
      check_eq("busy_after", 32'(bus_a.busy), 32'd0);
      check_eq("pix_valid_after", 32'(bus_a.pix_valid), 32'd0);
      check_eq("char_ready_after", 32'(bus_a.char_ready), 32'd1);
      check_eq("first_rom_ce", 32'(first_ce), 32'd1);
      check_eq("first_pix_valid", 32'(first_pv), 32'd3);
      if (!rnd) check_eq("glyph_cycles", 32'(t - 1), 32'(10 * RowsA));
      check_eq("rom_ad_count", 32'(ads.size()), 32'(RowsA));
      for (int r = 0; r < ads.size() && r < int'(RowsA); r++) begin
         check_eq("rom_ad", 32'(ads[r]), 32'({code, 4'(r)}));
      end
   endtask

   task automatic render_b(input logic [7:0] code, input logic [15:0] fg, input logic [15:0] bg);
      int          wait_n = 0;
      int          t = 1;
      int          npix = 0;
      logic [11:0] ads[$];
      bus_b.char_code  = code;
      bus_b.fg_color   = fg;
      bus_b.bg_color   = bg;
      bus_b.char_valid = 1'b1;
      while (!bus_b.char_ready && wait_n < 40) begin
         @(negedge clk);
         wait_n++;
      end
      check_eq("b_char_ready", 32'(bus_b.char_ready), 32'd1);
      if (!bus_b.char_ready) return;
      @(negedge clk);
      bus_b.char_valid = 1'b0;
      while (npix < 8 * int'(RowsB) && t < 200) begin
         if (bus_b.rom_ce) ads.push_back(bus_b.rom_ad);
         if (bus_b.pix_valid) begin
            check_eq("b_pix_data", 32'(bus_b.pix_data), 32'(exp_pix(code, npix, fg, bg, 1'b0)));
            check_eq("b_pix_last", 32'(bus_b.pix_last), 32'(npix == 8 * int'(RowsB) - 1));
            npix++;
         end
         @(negedge clk);
         t++;
      end
      check_eq("b_pixel_count", 32'(npix), 32'(8 * RowsB));
      check_eq("b_glyph_cycles", 32'(t - 1), 32'(10 * RowsB));
      check_eq("b_busy_after", 32'(bus_b.busy), 32'd0);
      check_eq("b_rom_ad_count", 32'(ads.size()), 32'(RowsB));
      for (int r = 0; r < ads.size() && r < int'(RowsB); r++) begin
         check_eq("b_rom_ad", 32'(ads[r]), 32'({code, 4'(r)}));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_char_ready"}, 32'(bus_a.char_ready), 32'd0);
      check_eq({tag, "_pix_valid"}, 32'(bus_a.pix_valid), 32'd0);
      check_eq({tag, "_pix_last"}, 32'(bus_a.pix_last), 32'd0);
      check_eq({tag, "_busy"}, 32'(bus_a.busy), 32'd0);
      check_eq({tag, "_rom_ce"}, 32'(bus_a.rom_ce), 32'd0);
      check_eq({tag, "_rom_oce"}, 32'(bus_a.rom_oce), 32'd0);
      check_eq({tag, "_rom_ad"}, 32'(bus_a.rom_ad), 32'd0);
      check_eq({tag, "_pix_data"}, 32'(bus_a.pix_data), 32'd0);
      check_eq({tag, "_b_char_ready"}, 32'(bus_b.char_ready), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus_a.char_valid = 1'b0;
      bus_a.char_code  = 8'h00;
      bus_a.fg_color   = 16'h0000;
      bus_a.bg_color   = 16'h0000;
      bus_a.pix_ready  = 1'b1;
      bus_b.char_valid = 1'b0;
      bus_b.char_code  = 8'h00;
      bus_b.fg_color   = 16'h0000;
      bus_b.bg_color   = 16'h0000;
      bus_b.pix_ready  = 1'b1;
      #1 rst_n = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_reset", 32'(bus_a.char_ready), 32'd1);
      check_eq("busy_after_reset", 32'(bus_a.busy), 32'd0);

      rom_mode  = 0;
      rom_const = 8'hA5;
      render_a(8'h41, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 8'h00, -1, 1'b0);
      rom_const = 8'h80;
      render_a(8'h41, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 8'h00, -1, 1'b0);
      rom_const = 8'hA5;
      render_a(8'h41, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 8'h00, -1, 1'b0);

      // Back-to-back: request held high across the glyph boundary.
      rom_mode = 1;
      render_a(8'h00, 16'h1234, 16'hABCD, 1'b0, 1'b1, 8'hFF, -1, 1'b0);
      render_a(8'hFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 8'h00, -1, 1'b1);

      for (int i = 0; i < 3; i++) begin
         render_a(8'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0, 8'h00, -1, 1'b0);
      end

      // Abort mid-glyph at row 5, column 3.
      rom_mode  = 0;
      rom_const = 8'hA5;
      render_a(8'h41, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 8'h00, 5 * 8 + 3, 1'b0);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("abort");
      repeat (3) begin
         @(negedge clk);
         check_eq("abort_hold_valid", 32'(bus_a.pix_valid), 32'd0);
         check_eq("abort_hold_rom_ce", 32'(bus_a.rom_ce), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_abort", 32'(bus_a.char_ready), 32'd1);
      rom_mode = 1;
      render_a(8'h30, 16'h07E0, 16'hF800, 1'b0, 1'b0, 8'h00, -1, 1'b0);

      rom_mode  = 0;
      rom_const = 8'hA5;
      render_b(8'h41, 16'hFFFF, 16'h0000);
      rom_const = 8'h80;
      render_b(8'h41, 16'hFFFF, 16'h0000);
      rom_mode = 1;
      for (int i = 0; i < 2; i++) begin
         render_b(8'($urandom), 16'($urandom), 16'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
